kf_alu_seq: RTL and testbench
=============================

Name: kf_alu_seq

Overview:
- Datapath sequencer that sits directly in front of mem_reg. It accepts one arithmetic command at a time, drives mem_reg's two read addresses, and consumes db_rdata_a/b.
- Computes a fixed-point ADD, SUB, MUL, MAC, MOV or RQ/RD load, then writes the result back through db_we/db_waddr/db_wdata, rq_we/rq_d or rd_we/rd_d.
- This is the Kalman update engine's only writer to the data bank.

Parameters:
- W, 24, data word width (signed two's complement).
- DEPTH, 40, data bank depth; must match mem_reg.
- ADDRW, 6, address width; 2^ADDRW >= DEPTH.
- FRAC, 12, fractional bits of the Q format (default Q11.12, 1.0 = 24'h001000).
- LENW, 6, width of the MAC length field.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 MAC, 4 MOV, 5 LDRQ, 6 LDRD, 7 illegal.
- cmd_a  in  ADDRW  source A base address.
- cmd_b  in  ADDRW  source B base address.
- cmd_d  in  ADDRW  destination address.
- cmd_len  in  LENW  MAC element count minus 1; ignored for other ops.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command retires.
- err  out  1  one-cycle pulse together with done for op 7.
- db_raddr_a, db_raddr_b  out  ADDRW  mem_reg read addresses.
- db_rdata_a, db_rdata_b  in  W  mem_reg read data; combinational, same cycle.
- db_we  out  1; db_waddr  out  ADDRW; db_wdata  out  W  bank write port.
- rq_we  out  1; rq_d  out  W  RQ register load.
- rd_we  out  1; rd_d  out  W  RD register load.
- sat_sticky  out  1  present only with KF_SAT_FLAG_EN.

Behaviour:
- Reset: state=IDLE. busy, done, err, db_we, rq_we and rd_we are 0. All address and data outputs are 0. The accumulator and operand registers clear.
- Reset mid-command aborts the command. No write strobe is asserted in the cycle after rst is sampled.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields and go to READ. For op 7, go straight to WRITE with no strobes; done=err=1 in that cycle.
- READ: drive db_raddr_a = a_ptr and db_raddr_b = b_ptr. Register db_rdata_a/b into opA/opB at the end of the cycle. Go to EXEC.
- EXEC: compute on opA/opB.
  - MAC with remaining count > 0: increment a_ptr and b_ptr, decrement the count, return to READ.
  - Otherwise go to WRITE.
- WRITE: exactly one strobe is high for one cycle; done=1; then IDLE.
  - db_we for ADD, SUB, MUL, MAC, MOV, with db_waddr = cmd_d.
  - rq_we for LDRQ.
  - rd_we for LDRD.
- Latency from accept edge to done:
  - ADD, SUB, MUL, MOV, LDRQ, LDRD: 3 cycles.
  - MAC: 2*(cmd_len+1)+1 cycles.
  - Op 7: 1 cycle.
- No new command is accepted in the WRITE cycle. Commands are issued no faster than one every latency+1 cycles.
- Pointer wrap: a pointer incremented from DEPTH-1 goes to 0, not 2^ADDRW.
- Destination equal to a source is legal: all reads complete before the write.
- Arithmetic:
  - ADD/SUB: full W+1-bit result, saturated to [-2^(W-1), 2^(W-1)-1].
  - MUL: 2W-bit signed product. Add 2^(FRAC-1), arithmetic shift right by FRAC, saturate to W.
  - MAC: sum full 2W-bit products in a 2W+LENW-bit accumulator, with no intermediate rounding. Round, shift and saturate once in WRITE, as for MUL.
  - MOV, LDRQ, LDRD: result = opA unchanged. The B port is still driven but ignored.
- db_wdata, rq_d and rd_d hold the last result between writes. They are only meaningful while the matching strobe is high.

Optional Feature:
- KF_SAT_FLAG_EN defined:
  - Adds output sat_sticky.
  - It is set in the WRITE cycle of any command whose result clipped.
  - It stays set until rst. Accepting further commands does not clear it.
- Not defined: the port and its logic are absent. Saturation still clips, silently.

Test Plan:
- Preload bank[0]=24'h002000 (2.0) and bank[1]=24'h001800 (1.5). Issue MUL a=0 b=1 d=2 -> db_we high exactly 3 cycles after accept, db_waddr=2, db_wdata=24'h003000, done pulse coincident.
- ADD of 24'h7FFFFF and 24'h000001 -> 24'h7FFFFF written. SUB of 24'h800000 minus 24'h000001 -> 24'h800000. With KF_SAT_FLAG_EN, sat_sticky rises in the first WRITE and stays 1.
- MAC with a=DEPTH-2, b=4, len=2, bank[DEPTH-2]=bank[DEPTH-1]=bank[0]=24'h001000 and bank[4..6]=24'h000800:
  - db_raddr_a sequence DEPTH-2, DEPTH-1, 0 (wrap).
  - Result 24'h001800; done at cycle 7 after accept.
- Rounding: MUL 24'h000001 * 24'h000800 -> 24'h000001 (round half up). MUL 24'hFFFFFF * 24'h000800 -> 24'h000000.
- LDRQ a=0 -> rq_we one cycle, rq_d=24'h002000, db_we stays 0. LDRD likewise drives only rd_we. Op 7 -> done=err=1 one cycle after accept, no strobes.
- Assert rst during the second READ of a MAC with len=5 -> next cycle busy=0, cmd_ready=1, no db_we ever asserted. A following ADD completes normally.

Source files
------------

// File: rtl/kf_alu_seq.sv
// -----------------------------------------------------------------------------
// kf_alu_seq
// Datapath sequencer that sits in front of mem_reg. It takes one arithmetic
// command at a time, reads its operands through mem_reg's two combinational
// read ports, and writes back one fixed-point result. The result goes to the
// data bank, to the RQ register or to the RD register.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only while idle)
//   cmd_op, cmd_a, cmd_b,     opcode, source A/B base, destination and
//   cmd_d, cmd_len            MAC element count minus one
//   busy, done, err           status; done/err pulse for one cycle
//   db_raddr_a/b, db_rdata_a/b  mem_reg read ports (data valid same cycle)
//   db_we, db_waddr, db_wdata   mem_reg write port
//   rq_we, rq_d / rd_we, rd_d   RQ and RD register loads
//   sat_sticky                sticky saturation flag (only with the macro)
//
// Optional feature macro: KF_SAT_FLAG_EN adds the sat_sticky output.
// -----------------------------------------------------------------------------
module kf_alu_seq #(
  parameter int W     = 24,
  parameter int DEPTH = 40,
  parameter int ADDRW = 6,
  parameter int FRAC  = 12,
  parameter int LENW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [ADDRW-1:0] cmd_a,
  input  logic [ADDRW-1:0] cmd_b,
  input  logic [ADDRW-1:0] cmd_d,
  input  logic [LENW-1:0]  cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ADDRW-1:0] db_raddr_a,
  output logic [ADDRW-1:0] db_raddr_b,
  input  logic [W-1:0]     db_rdata_a,
  input  logic [W-1:0]     db_rdata_b,
  output logic             db_we,
  output logic [ADDRW-1:0] db_waddr,
  output logic [W-1:0]     db_wdata,
  output logic             rq_we,
  output logic [W-1:0]     rq_d,
  output logic             rd_we,
  output logic [W-1:0]     rd_d
`ifdef KF_SAT_FLAG_EN
  ,
  output logic             sat_sticky
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_MAC  = 3'd3;
  localparam logic [2:0] OP_MOV  = 3'd4;
  localparam logic [2:0] OP_LDRQ = 3'd5;
  localparam logic [2:0] OP_LDRD = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  // Accumulator is wide enough to sum 2^LENW full-precision products.
  localparam int AW = 2*W + LENW;
  localparam logic signed [AW-1:0] RND    = AW'(1) << (FRAC-1);
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         MAX_W  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         MIN_W  = {1'b1, {(W-1){1'b0}}};
  localparam logic [ADDRW-1:0]     LAST   = ADDRW'(DEPTH-1);

  logic [1:0]             state;
  logic [2:0]             op;
  logic [ADDRW-1:0]       a_ptr;
  logic [ADDRW-1:0]       b_ptr;
  logic [ADDRW-1:0]       d_addr;
  logic [LENW-1:0]        count;
  logic signed [W-1:0]    op_a;
  logic signed [W-1:0]    op_b;
  logic signed [AW-1:0]   acc;
  logic [W-1:0]           res;

  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   acc_sum;
  logic signed [AW-1:0]   rnd_in;
  logic signed [AW-1:0]   rnd_add;
  logic signed [AW-1:0]   rnd_sh;
  logic signed [W:0]      add_sum;
  logic signed [W:0]      sub_diff;
  logic                   add_ovf;
  logic                   sub_ovf;
  logic                   rnd_hi;
  logic                   rnd_lo;
  logic [W-1:0]           res_next;
  logic                   exec_last;

  // The last EXEC of a command is the one that does not loop back for
  // another MAC element; the result register is loaded there.
  assign exec_last = (state == S_EXEC) && !((op == OP_MAC) && (count != '0));

  // Result datapath. Products are formed at full 2W precision and sign
  // extended into the accumulator width so that MUL and MAC share one
  // round/shift/saturate path. For MAC the final element is folded in here,
  // so rounding happens exactly once on the complete sum.
  always_comb begin
    prod     = $signed({{W{op_a[W-1]}}, op_a}) * $signed({{W{op_b[W-1]}}, op_b});
    prod_ext = $signed({{LENW{prod[2*W-1]}}, prod});
    acc_sum  = acc + prod_ext;
    add_sum  = $signed({op_a[W-1], op_a}) + $signed({op_b[W-1], op_b});
    sub_diff = $signed({op_a[W-1], op_a}) - $signed({op_b[W-1], op_b});
    add_ovf  = add_sum[W] ^ add_sum[W-1];
    sub_ovf  = sub_diff[W] ^ sub_diff[W-1];
    rnd_in   = (op == OP_MAC) ? acc_sum : prod_ext;
    rnd_add  = rnd_in + RND;
    rnd_sh   = rnd_add >>> FRAC;
    rnd_hi   = rnd_sh > SAT_HI;
    rnd_lo   = rnd_sh < SAT_LO;
    res_next = op_a;
    case (op)
      OP_ADD: begin
        if (add_ovf) res_next = add_sum[W] ? MIN_W : MAX_W;
        else         res_next = add_sum[W-1:0];
      end
      OP_SUB: begin
        if (sub_ovf) res_next = sub_diff[W] ? MIN_W : MAX_W;
        else         res_next = sub_diff[W-1:0];
      end
      OP_MUL, OP_MAC: begin
        if (rnd_hi)      res_next = MAX_W;
        else if (rnd_lo) res_next = MIN_W;
        else             res_next = rnd_sh[W-1:0];
      end
      default: res_next = op_a;
    endcase
  end

  // Sequencer. IDLE latches the command, READ captures both operands from
  // mem_reg, EXEC either steps the MAC pointers and loops back or loads the
  // result, WRITE presents the result for one cycle. Pointers wrap at the
  // bank depth rather than at the address-width boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op     <= OP_ADD;
      a_ptr  <= '0;
      b_ptr  <= '0;
      d_addr <= '0;
      count  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      res    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op     <= cmd_op;
            a_ptr  <= cmd_a;
            b_ptr  <= cmd_b;
            d_addr <= cmd_d;
            count  <= cmd_len;
            acc    <= '0;
            state  <= (cmd_op == OP_ILL) ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          op_a  <= db_rdata_a;
          op_b  <= db_rdata_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_last) begin
            res   <= res_next;
            state <= S_WRITE;
          end else begin
            acc   <= acc_sum;
            a_ptr <= (a_ptr == LAST) ? '0 : a_ptr + 1'b1;
            b_ptr <= (b_ptr == LAST) ? '0 : b_ptr + 1'b1;
            count <= count - 1'b1;
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KF_SAT_FLAG_EN
  logic clip;
  logic clip_next;

  // Clipping is detected alongside the result and remembered until WRITE,
  // where it sets the sticky flag. Only a reset clears the flag.
  always_comb begin
    clip_next = 1'b0;
    case (op)
      OP_ADD:         clip_next = add_ovf;
      OP_SUB:         clip_next = sub_ovf;
      OP_MUL, OP_MAC: clip_next = rnd_hi | rnd_lo;
      default:        clip_next = 1'b0;
    endcase
  end

  // Sticky flag register and the per-command clip marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip       <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      if ((state == S_IDLE) && cmd_valid) clip <= 1'b0;
      else if (exec_last)                 clip <= clip_next;
      if ((state == S_WRITE) && clip)     sat_sticky <= 1'b1;
    end
  end
`endif

  // Status and strobes decode directly from the registered state, so a
  // reset leaves every strobe low in the following cycle.
  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_WRITE);
  assign err        = done && (op == OP_ILL);
  assign db_we      = done && (op <= OP_MOV);
  assign rq_we      = done && (op == OP_LDRQ);
  assign rd_we      = done && (op == OP_LDRD);
  assign db_raddr_a = a_ptr;
  assign db_raddr_b = b_ptr;
  assign db_waddr   = d_addr;
  assign db_wdata   = res;
  assign rq_d       = res;
  assign rd_d       = res;

endmodule

// File: tb/tb_kf_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_kf_alu_seq
// Self-checking bench for kf_alu_seq. The bench plays the role of mem_reg
// (a bank array with combinational reads) and keeps its own model copy of
// the bank, from which expected results are computed with plain integer
// arithmetic. Directed steps from the test plan come first, then a burst of
// random commands. Honours KF_SAT_FLAG_EN for the sticky flag.
// -----------------------------------------------------------------------------
module tb_kf_alu_seq;

  localparam int W     = 24;
  localparam int DEPTH = 40;
  localparam int ADDRW = 6;
  localparam int FRAC  = 12;
  localparam int LENW  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [ADDRW-1:0] cmd_a;
  logic [ADDRW-1:0] cmd_b;
  logic [ADDRW-1:0] cmd_d;
  logic [LENW-1:0]  cmd_len;
  logic             busy;
  logic             done;
  logic             err;
  logic [ADDRW-1:0] db_raddr_a;
  logic [ADDRW-1:0] db_raddr_b;
  logic [W-1:0]     db_rdata_a;
  logic [W-1:0]     db_rdata_b;
  logic             db_we;
  logic [ADDRW-1:0] db_waddr;
  logic [W-1:0]     db_wdata;
  logic             rq_we;
  logic [W-1:0]     rq_d;
  logic             rd_we;
  logic [W-1:0]     rd_d;
`ifdef KF_SAT_FLAG_EN
  logic             sat_sticky;
  logic             stick_m = 1'b0;
`endif

  logic [W-1:0]     bank [DEPTH];
  logic [W-1:0]     mdl  [DEPTH];
  logic             pre_we = 1'b0;
  logic [ADDRW-1:0] pre_addr = '0;
  logic [W-1:0]     pre_data = '0;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               lat;
  int               n_db;
  int               n_rq;
  int               n_rd;
  int               n_err;
  logic             we_at_done;
  logic             got;
  logic             tmp;
  logic [ADDRW-1:0] cap_waddr;
  logic [W-1:0]     cap_wdata;
  logic [W-1:0]     cap_rq;
  logic [W-1:0]     cap_rd;
  logic [ADDRW-1:0] ra [32];

  always #5 clk = ~clk;

  kf_alu_seq #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW), .FRAC(FRAC), .LENW(LENW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .db_raddr_a(db_raddr_a), .db_raddr_b(db_raddr_b),
    .db_rdata_a(db_rdata_a), .db_rdata_b(db_rdata_b),
    .db_we(db_we), .db_waddr(db_waddr), .db_wdata(db_wdata),
    .rq_we(rq_we), .rq_d(rq_d), .rd_we(rd_we), .rd_d(rd_d)
`ifdef KF_SAT_FLAG_EN
    , .sat_sticky(sat_sticky)
`endif
  );

  // Bank stand-in for mem_reg: bench preloads take priority over DUT writes.
  always @(posedge clk) begin
    if (pre_we) bank[pre_addr] <= pre_data;
    else if (db_we && (db_waddr < DEPTH)) bank[db_waddr] <= db_wdata;
  end

  assign db_rdata_a = (db_raddr_a < DEPTH) ? bank[db_raddr_a] : '0;
  assign db_rdata_b = (db_raddr_b < DEPTH) ? bank[db_raddr_b] : '0;

  // Watchdog so a wedged design still ends the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rshift(input longint p);
    return (p + (longint'(1) <<< (FRAC-1))) >>> FRAC;
  endfunction

  // Reference result {clipped, value} from the model bank contents.
  function automatic logic [W:0] model(input int op, input int a, input int b, input int len);
    longint r;
    longint acc;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    case (op)
      0: r = sx(mdl[a]) + sx(mdl[b]);
      1: r = sx(mdl[a]) - sx(mdl[b]);
      2: r = rshift(sx(mdl[a]) * sx(mdl[b]));
      3: begin
        acc = 0;
        for (int k = 0; k <= len; k++)
          acc += sx(mdl[(a+k) % DEPTH]) * sx(mdl[(b+k) % DEPTH]);
        r = rshift(acc);
      end
      default: r = sx(mdl[a]);
    endcase
    if (r > hi) return {1'b1, hi[W-1:0]};
    if (r < lo) return {1'b1, lo[W-1:0]};
    return {1'b0, r[W-1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic preload_word(input int addr, input logic [W-1:0] val);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = ADDRW'(addr);
    pre_data = val;
    mdl[addr] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one command and watches it until done, capturing latency,
  // strobe counts, write data and the A read address of each cycle.
  task automatic applyStimulus(input int op, input int a, input int b, input int d, input int len);
    @(negedge clk);
    checkOutput("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_a     = ADDRW'(a);
    cmd_b     = ADDRW'(b);
    cmd_d     = ADDRW'(d);
    cmd_len   = LENW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1; n_db = 0; n_rq = 0; n_rd = 0; n_err = 0; got = 1'b0; we_at_done = 1'b0;
    for (int c = 1; c <= 300 && !got; c++) begin
      if (c < 32) ra[c] = db_raddr_a;
      if (db_we) begin n_db++; cap_waddr = db_waddr; cap_wdata = db_wdata; end
      if (rq_we) begin n_rq++; cap_rq = rq_d; end
      if (rd_we) begin n_rd++; cap_rd = rd_d; end
      if (err) n_err++;
      if (done) begin
        lat = c;
        got = 1'b1;
        we_at_done = db_we;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic run_cmd(input int op, input int a, input int b, input int d, input int len, input string tag);
    logic [W:0] m;
    int elat;
    m    = model(op, a, b, len);
    elat = (op == 7) ? 1 : (op == 3) ? 2*(len+1)+1 : 3;
    applyStimulus(op, a, b, d, len);
    checkOutput({tag, ".latency"}, lat, elat);
    checkOutput({tag, ".err"}, n_err, (op == 7));
    checkOutput({tag, ".db_we"}, n_db, (op <= 4));
    checkOutput({tag, ".rq_we"}, n_rq, (op == 5));
    checkOutput({tag, ".rd_we"}, n_rd, (op == 6));
    if (op <= 4) begin
      checkOutput({tag, ".waddr"}, cap_waddr, d);
      checkOutput({tag, ".wdata"}, cap_wdata, m[W-1:0]);
      mdl[d] = m[W-1:0];
    end else if (op == 5) begin
      checkOutput({tag, ".rq_d"}, cap_rq, m[W-1:0]);
    end else if (op == 6) begin
      checkOutput({tag, ".rd_d"}, cap_rd, m[W-1:0]);
    end
    @(negedge clk);
    checkOutput({tag, ".idle_after"}, busy, 0);
`ifdef KF_SAT_FLAG_EN
    if (op != 7) stick_m = stick_m | m[W];
    checkOutput({tag, ".sat_sticky"}, sat_sticky, stick_m);
`endif
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_d = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.err", err, 0);
    checkOutput("rst.strobes", {db_we, rq_we, rd_we}, 0);
    checkOutput("rst.ready", cmd_ready, 1);
    checkOutput("rst.addrs", {db_raddr_a, db_raddr_b, db_waddr}, 0);
    checkOutput("rst.data", {db_wdata, rd_d}, 0);
`ifdef KF_SAT_FLAG_EN
    checkOutput("rst.sat_sticky", sat_sticky, 0);
`endif
    rst = 1'b0;
    $display("[TB] reset checks done, filling bank");

    for (int i = 0; i < DEPTH; i++)
      preload_word(i, $urandom_range(0, 1) ? W'($urandom) : W'(int'($urandom_range(0, 24576)) - 12288));

    preload_word(0, 24'h002000);
    preload_word(1, 24'h001800);
    run_cmd(2, 0, 1, 2, 0, "mul_basic");
    checkOutput("mul_basic.lit_wdata", cap_wdata, 24'h003000);
    checkOutput("mul_basic.lit_lat", lat, 3);
    checkOutput("mul_basic.we_with_done", we_at_done, 1);

    preload_word(8, 24'h7FFFFF);
    preload_word(9, 24'h000001);
    preload_word(11, 24'h800000);
    run_cmd(0, 8, 9, 10, 0, "add_sat");
    checkOutput("add_sat.lit_wdata", cap_wdata, 24'h7FFFFF);
`ifdef KF_SAT_FLAG_EN
    checkOutput("add_sat.lit_sticky", sat_sticky, 1);
`endif
    run_cmd(1, 11, 9, 12, 0, "sub_sat");
    checkOutput("sub_sat.lit_wdata", cap_wdata, 24'h800000);

    preload_word(DEPTH-2, 24'h001000);
    preload_word(DEPTH-1, 24'h001000);
    preload_word(0, 24'h001000);
    for (int i = 4; i <= 6; i++) preload_word(i, 24'h000800);
    run_cmd(3, DEPTH-2, 4, 13, 2, "mac_wrap");
    checkOutput("mac_wrap.lit_wdata", cap_wdata, 24'h001800);
    checkOutput("mac_wrap.lit_lat", lat, 7);
    checkOutput("mac_wrap.raddr0", ra[1], DEPTH-2);
    checkOutput("mac_wrap.raddr1", ra[3], DEPTH-1);
    checkOutput("mac_wrap.raddr2", ra[5], 0);

    preload_word(14, 24'h000001);
    preload_word(15, 24'h000800);
    preload_word(16, 24'hFFFFFF);
    run_cmd(2, 14, 15, 17, 0, "round_pos");
    checkOutput("round_pos.lit_wdata", cap_wdata, 24'h000001);
    run_cmd(2, 16, 15, 18, 0, "round_neg");
    checkOutput("round_neg.lit_wdata", cap_wdata, 24'h000000);

    preload_word(0, 24'h002000);
    run_cmd(5, 0, 1, 0, 0, "ldrq");
    checkOutput("ldrq.lit_rq_d", cap_rq, 24'h002000);
    run_cmd(6, 1, 0, 0, 0, "ldrd");
    checkOutput("ldrd.lit_rd_d", cap_rd, 24'h001800);
    run_cmd(7, 3, 4, 5, 0, "illegal");
    checkOutput("illegal.lit_lat", lat, 1);
    run_cmd(4, 1, 2, 19, 0, "mov");
    checkOutput("mov.lit_wdata", cap_wdata, 24'h001800);
    run_cmd(0, 20, 20, 20, 0, "add_dest_is_src");

    $display("[TB] reset during MAC");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 6'd0; cmd_b = 6'd1; cmd_d = 6'd21; cmd_len = 6'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    tmp = db_we;
    @(negedge clk);
    tmp = tmp | db_we;
    @(negedge clk);
    tmp = tmp | db_we;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst.busy", busy, 0);
    checkOutput("midrst.ready", cmd_ready, 1);
    checkOutput("midrst.done", done, 0);
    tmp = tmp | db_we;
    repeat (15) begin
      @(negedge clk);
      tmp = tmp | db_we;
    end
    checkOutput("midrst.no_db_we", tmp, 0);
`ifdef KF_SAT_FLAG_EN
    stick_m = 1'b0;
    checkOutput("midrst.sat_sticky", sat_sticky, 0);
`endif
    run_cmd(0, 0, 1, 22, 0, "add_after_rst");

    $display("[TB] random commands");
    for (int n = 0; n < 25; n++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
      run_cmd(op, int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)),
              int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 7)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
